// File: rtl/aclk_core_if.sv
// Load/alarm control and BCD time display bundle for the alarm clock core.
interface aclk_core_if;
   logic [1:0] H_in1;
   logic [3:0] H_in0;
   logic [3:0] M_in1;
   logic [3:0] M_in0;
   logic       LD_time;
   logic       LD_alarm;
   logic       AL_ON;
   logic       STOP_al;
   logic [1:0] H_out1;
   logic [3:0] H_out0;
   logic [3:0] M_out1;
   logic [3:0] M_out0;
   logic [3:0] S_out1;
   logic [3:0] S_out0;
   logic       Alarm;

   modport master (
      output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, AL_ON, STOP_al,
      input  H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, Alarm
   );

   modport slave (
      input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, AL_ON, STOP_al,
      output H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, Alarm
   );
endinterface

// File: rtl/aclk_core.sv
// 24-hour BCD alarm clock: divide-by-10 prescaler, HH:MM:SS counter, HH:MM alarm
// compare with a registered, sticky alarm output.
module aclk_core (
   input logic         clk,
   input logic         reset,
   aclk_core_if.slave  bus
);

   logic [3:0] presc_q, presc_d;
   logic [1:0] h1_q, h1_d;
   logic [3:0] h0_q, h0_d;
   logic [3:0] m1_q, m1_d;
   logic [3:0] m0_q, m0_d;
   logic [3:0] s1_q, s1_d;
   logic [3:0] s0_q, s0_d;
   logic [1:0] ah1_q, ah1_d;
   logic [3:0] ah0_q, ah0_d;
   logic [3:0] am1_q, am1_d;
   logic [3:0] am0_q, am0_d;
   logic       alarm_q, alarm_d;

   logic tick;
   logic in_valid;
   logic match;

   assign tick = (presc_q == 4'd9);

   assign in_valid = (bus.H_in1 <= 2'd2) && (bus.H_in0 <= 4'd9) &&
                     !((bus.H_in1 == 2'd2) && (bus.H_in0 > 4'd3)) &&
                     (bus.M_in1 <= 4'd5) && (bus.M_in0 <= 4'd9);

   // Only the first cycle of the matching second counts, so a stopped alarm stays stopped.
   assign match = (presc_q == 4'd0) && (h1_q == ah1_q) && (h0_q == ah0_q) &&
                  (m1_q == am1_q) && (m0_q == am0_q) && (s1_q == 4'd0) && (s0_q == 4'd0);

   always_comb begin
      presc_d = tick ? 4'd0 : presc_q + 4'd1;
      h1_d    = h1_q;
      h0_d    = h0_q;
      m1_d    = m1_q;
      m0_d    = m0_q;
      s1_d    = s1_q;
      s0_d    = s0_q;
      ah1_d   = ah1_q;
      ah0_d   = ah0_q;
      am1_d   = am1_q;
      am0_d   = am0_q;
      alarm_d = alarm_q;

      if (tick) begin
         if (s0_q != 4'd9) begin
            s0_d = s0_q + 4'd1;
         end else begin
            s0_d = 4'd0;
            if (s1_q != 4'd5) begin
               s1_d = s1_q + 4'd1;
            end else begin
               s1_d = 4'd0;
               if (m0_q != 4'd9) begin
                  m0_d = m0_q + 4'd1;
               end else begin
                  m0_d = 4'd0;
                  if (m1_q != 4'd5) begin
                     m1_d = m1_q + 4'd1;
                  end else begin
                     m1_d = 4'd0;
                     if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
                        h1_d = 2'd0;
                        h0_d = 4'd0;
                     end else if (h0_q == 4'd9) begin
                        h1_d = h1_q + 2'd1;
                        h0_d = 4'd0;
                     end else begin
                        h0_d = h0_q + 4'd1;
                     end
                  end
               end
            end
         end
      end

      // A valid time load wins over a coincident tick.
      if (bus.LD_time && in_valid) begin
         h1_d    = bus.H_in1;
         h0_d    = bus.H_in0;
         m1_d    = bus.M_in1;
         m0_d    = bus.M_in0;
         s1_d    = 4'd0;
         s0_d    = 4'd0;
         presc_d = 4'd0;
      end

      if (bus.LD_alarm && in_valid) begin
         ah1_d = bus.H_in1;
         ah0_d = bus.H_in0;
         am1_d = bus.M_in1;
         am0_d = bus.M_in0;
      end

      if (!bus.AL_ON || bus.STOP_al) begin
         alarm_d = 1'b0;
      end else if (match) begin
         alarm_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= 4'd0;
         h1_q    <= 2'd0;
         h0_q    <= 4'd0;
         m1_q    <= 4'd0;
         m0_q    <= 4'd0;
         s1_q    <= 4'd0;
         s0_q    <= 4'd0;
         ah1_q   <= 2'd0;
         ah0_q   <= 4'd0;
         am1_q   <= 4'd0;
         am0_q   <= 4'd0;
         alarm_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         h1_q    <= h1_d;
         h0_q    <= h0_d;
         m1_q    <= m1_d;
         m0_q    <= m0_d;
         s1_q    <= s1_d;
         s0_q    <= s0_d;
         ah1_q   <= ah1_d;
         ah0_q   <= ah0_d;
         am1_q   <= am1_d;
         am0_q   <= am0_d;
         alarm_q <= alarm_d;
      end
   end

   assign bus.H_out1 = h1_q;
   assign bus.H_out0 = h0_q;
   assign bus.M_out1 = m1_q;
   assign bus.M_out0 = m0_q;
   assign bus.S_out1 = s1_q;
   assign bus.S_out0 = s0_q;
   assign bus.Alarm  = alarm_q;

endmodule
